// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit UART receiver with oversampled bit-centre detection.
// The line is synchronized, a falling edge opens a frame, and every bit is
// sampled in the middle of its period. Each byte is offered on a held-valid /
// acknowledge interface, and framing, parity and overrun errors are flagged.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// between the data and the stop bit (otherwise the frame is plain 8N1).
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic       data_in,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic          sync_q1;
  logic          sync_q2;
  logic          rx_line;
  logic          line_prev;
  logic [2:0]    state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          stop_event;

  assign rx_line    = sync_q2;
  assign stop_event = rx_en && (state == ST_STOP) && (tick_cnt == FULL_M1);

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  logic parity_ok;
  assign parity_ok = ~^{shift_reg, parity_bit};
`else
  assign parity_err = 1'b0;
`endif

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= data_in;
      sync_q2 <= sync_q1;
    end
  end

  // Frame sequencer: advances only on oversample ticks and samples bit centres.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_prev <= 1'b1;
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (rx_en) begin
      line_prev <= rx_line;
      case (state)
        ST_IDLE: begin
          if (line_prev && !rx_line) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick_cnt == HALF_M1) begin
            tick_cnt <= '0;
            if (!rx_line) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (tick_cnt == FULL_M1) begin
            tick_cnt  <= '0;
            shift_reg <= {rx_line, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            tick_cnt <= tick_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick_cnt == FULL_M1) begin
            tick_cnt   <= '0;
            parity_bit <= rx_line;
            state      <= ST_STOP;
          end else begin
            tick_cnt <= tick_cnt + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tick_cnt == FULL_M1) begin
            tick_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            tick_cnt <= tick_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result handling: load good bytes, hold valid until acked, pulse errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (data_ack && data_valid) begin
        data_valid <= 1'b0;
      end
      if (stop_event) begin
        if (!rx_line) begin
          frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
        end else if (!parity_ok) begin
          parity_err <= 1'b1;
`endif
        end else if (!data_valid || data_ack) begin
          data_out   <= shift_reg;
          data_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver.
// Stimulus pushes the expected event for each frame into a queue; a monitor
// pops and compares whenever the DUT presents a byte or an error pulse.
// Honours UART_RX_PARITY_EN to build 11-bit frames and run the parity cases.
module tb_uart_receiver;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // 2 synchronizer clocks + 1 edge-detect clock, then the stop-bit sample tick
  localparam int LAT = 3 + OS / 2 + (FRAME_BITS - 1) * OS;
  localparam int MAXC = 1 << 30;

  localparam int EV_NONE    = 0;
  localparam int EV_VALID   = 1;
  localparam int EV_FRAME   = 2;
  localparam int EV_PARITY  = 3;
  localparam int EV_OVERRUN = 4;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  rxDiv = 1;
  int  divCnt = 0;
  bit  autoAck = 0;
  bit  lastValid = 0;
  logic [7:0] lastOut = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en;
  logic       data_in = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_en      (rx_en),
    .data_in    (data_in),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun_err(overrun_err)
  );

  assign rx_en = (divCnt == 0);

  always #5 clk = ~clk;

  // Cycle counter for latency checks and divider for the oversample tick.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    divCnt <= (divCnt + 1 >= rxDiv) ? 0 : divCnt + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic handleEvent(input int kind, input logic [7:0] data);
    ev_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: got kind %0d data 'h%0h at cycle %0d, expected none",
               kind, data, cyc);
    end else begin
      e = expQ.pop_front();
      checkOutput("event_kind", kind, e.kind);
      if (kind == EV_VALID) checkOutput("event_data", int'(data), int'(e.data));
      if (e.cyc >= 0) checkOutput("event_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: every new byte and every error pulse consumes one expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      lastValid = 1'b0;
      lastOut   = 8'h00;
    end else begin
      if (data_valid && (!lastValid || data_out !== lastOut)) handleEvent(EV_VALID, data_out);
      if (frame_err)   handleEvent(EV_FRAME, 8'h00);
      if (parity_err)  handleEvent(EV_PARITY, 8'h00);
      if (overrun_err) handleEvent(EV_OVERRUN, 8'h00);
      lastValid = data_valid;
      lastOut   = data_out;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ackPulse();
    data_ack = 1'b1;
    @(posedge clk);
    #1;
    data_ack = 1'b0;
  endtask

  // Drives one serial frame (optionally truncated) and records its expected outcome.
  task automatic applyStimulus(input logic [7:0] d, input bit stopBit, input bit parBit,
                               input int bitClks, input int maxCycles, input bit ackAtStop,
                               input int expKind, input bit timed);
    logic [FRAME_BITS-1:0] bits;
    ev_t e;
    int startCyc;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9] = parBit;
`else
    if (parBit) bits[0] = 1'b0;
`endif
    bits[FRAME_BITS-1] = stopBit;
    startCyc = cyc;
    if (expKind != EV_NONE) begin
      e.kind = expKind;
      e.data = (expKind == EV_VALID) ? d : 8'h00;
      e.cyc  = timed ? startCyc + LAT : -1;
      expQ.push_back(e);
    end
    for (int i = 0; i < FRAME_BITS * bitClks && i < maxCycles; i++) begin
      data_in  = bits[i / bitClks];
      data_ack = autoAck ? data_valid : (ackAtStop && (i == LAT - 1));
      @(posedge clk);
      #1;
    end
    data_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    rst_n   = 1'b0;
    data_in = 1'b1;
    idle(5);
    checkOutput("rst_data_out", int'(data_out), 'h00);
    checkOutput("rst_data_valid", int'(data_valid), 0);
    rst_n = 1'b1;
    idle(1000);
    checkOutput("idle_data_out", int'(data_out), 'h00);
    checkOutput("idle_data_valid", int'(data_valid), 0);
    checkOutput("idle_frame_err", int'(frame_err), 0);
    checkOutput("idle_parity_err", int'(parity_err), 0);
    checkOutput("idle_overrun_err", int'(overrun_err), 0);

    $display("[TB] single byte A5");
    applyStimulus(8'hA5, 1'b1, ^8'hA5, OS, MAXC, 1'b0, EV_VALID, 1'b1);
    checkOutput("a5_data_out", int'(data_out), 'hA5);
    checkOutput("a5_data_valid", int'(data_valid), 1);
    ackPulse();
    checkOutput("ack_clears_valid", int'(data_valid), 0);

    $display("[TB] glitch");
    data_in = 1'b0;
    idle(4);
    data_in = 1'b1;
    idle(40);
    checkOutput("glitch_valid", int'(data_valid), 0);

    $display("[TB] framing error with stuck-low line");
    applyStimulus(8'h3C, 1'b0, ^8'h3C, OS, MAXC, 1'b0, EV_FRAME, 1'b1);
    idle(300);
    checkOutput("frame_valid", int'(data_valid), 0);
    checkOutput("frame_data_out", int'(data_out), 'hA5);
    data_in = 1'b1;
    idle(40);

    $display("[TB] overrun");
    applyStimulus(8'h11, 1'b1, ^8'h11, OS, MAXC, 1'b0, EV_VALID, 1'b1);
    applyStimulus(8'h22, 1'b1, ^8'h22, OS, MAXC, 1'b0, EV_OVERRUN, 1'b1);
    idle(10);
    checkOutput("overrun_data_out", int'(data_out), 'h11);
    checkOutput("overrun_valid", int'(data_valid), 1);
    ackPulse();

    $display("[TB] ack coincident with completion");
    applyStimulus(8'h33, 1'b1, ^8'h33, OS, MAXC, 1'b0, EV_VALID, 1'b1);
    applyStimulus(8'h44, 1'b1, ^8'h44, OS, MAXC, 1'b1, EV_VALID, 1'b1);
    idle(5);
    checkOutput("coinc_data_out", int'(data_out), 'h44);
    checkOutput("coinc_valid", int'(data_valid), 1);
    ackPulse();
    checkOutput("coinc_ack_clears", int'(data_valid), 0);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity");
    applyStimulus(8'h07, 1'b1, 1'b1, OS, MAXC, 1'b0, EV_VALID, 1'b1);
    checkOutput("par_good_out", int'(data_out), 'h07);
    ackPulse();
    applyStimulus(8'h07, 1'b1, 1'b0, OS, MAXC, 1'b0, EV_PARITY, 1'b1);
    idle(5);
    checkOutput("par_bad_valid", int'(data_valid), 0);
`endif

    $display("[TB] slow tick");
    rxDiv = 3;
    idle(6);
    applyStimulus(8'h96, 1'b1, ^8'h96, OS * 3, MAXC, 1'b0, EV_VALID, 1'b0);
    idle(10);
    checkOutput("slow_data_out", int'(data_out), 'h96);
    ackPulse();
    rxDiv = 1;
    idle(10);

    $display("[TB] reset abort");
    applyStimulus(8'h5A, 1'b1, ^8'h5A, OS, 4 * OS, 1'b0, EV_NONE, 1'b0);
    data_in = 1'b1;
    rst_n   = 1'b0;
    idle(3);
    checkOutput("abort_data_out", int'(data_out), 'h00);
    checkOutput("abort_valid", int'(data_valid), 0);
    rst_n = 1'b1;
    idle(20);
    applyStimulus(8'hC3, 1'b1, ^8'hC3, OS, MAXC, 1'b0, EV_VALID, 1'b1);
    checkOutput("after_abort_out", int'(data_out), 'hC3);
    ackPulse();

    $display("[TB] loopback");
    autoAck = 1'b1;
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom_range(0, 255));
      applyStimulus(b, 1'b1, ^b, OS, MAXC, 1'b0, EV_VALID, 1'b1);
    end
    autoAck = 1'b0;
    idle(50);
    checkOutput("pending_events", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

- Serial-to-parallel receiver for the team's 8N1 UART link; counterpart of the existing UART transmitter.
- Oversamples the line on a clock-enable tick, locates the centre of each bit, and shifts in 8 data bits LSB first.
- Presents each received byte on a held-valid/acknowledge interface and flags framing, parity and overrun errors.
- Sits between the board RX pin and the consumer logic, in the same clock domain as the transmitter.

## Interface
- OVERSAMPLE, 16, rx_en ticks per bit period; must be even and ≥ 4. Counter width is $clog2(OVERSAMPLE).
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_en  input  1  oversample tick; must run at OVERSAMPLE × the transmitter's bit rate.
- data_in  input  1  serial line; idle high, asynchronous to clk.
- data_ack  input  1  consumer has taken data_out; clears data_valid.
- data_out  output  8  last good received byte.
- data_valid  output  1  level; byte available in data_out.
- frame_err  output  1  one-clk pulse; stop bit sampled low.
- parity_err  output  1  one-clk pulse; parity mismatch. Tied 0 without the macro.
- overrun_err  output  1  one-clk pulse; good byte dropped because data_valid was still set.

## Operation
- Input synchronizer: two flops on data_in, both reset to 1, always present. All decisions use the synchronized line.
- Counting happens only on cycles with rx_en=1. Outside ticks, state and counters hold.
- IDLE: on a tick, a 1→0 transition of the synchronized line moves to START and clears the tick counter.
  - A line held low (stuck, or after a framing error) does not start a frame; a new falling edge is required.
- START: after OVERSAMPLE/2 ticks, sample the line.
  - 0: go to DATA with the bit counter at 0.
  - 1: false start; return to IDLE with no outputs.
- DATA: every OVERSAMPLE ticks, sample one bit and shift it in at the MSB (shift right), giving LSB-first order. After the 8th bit, go to PARITY if the macro is set, otherwise to STOP.
- PARITY (macro only): after OVERSAMPLE ticks, sample the parity bit and compare against even parity (XOR of the 8 data bits and the parity bit must be 0).
- STOP: after OVERSAMPLE ticks, sample the stop bit, then return directly to IDLE without waiting out the stop-bit second half, so back-to-back frames are accepted.
  - Stop = 0: pulse frame_err; discard the byte.
  - Parity mismatch with stop = 1: pulse parity_err; discard the byte.
  - Good byte with data_valid = 0: load data_out and set data_valid.
  - Good byte with data_valid = 1 and no data_ack: pulse overrun_err; keep the old data_out.
- data_ack while data_valid = 1 clears data_valid the next clk. data_ack while data_valid = 0 is ignored.
- If data_ack and a good-byte completion occur in the same cycle, no overrun is flagged: the new byte is loaded and data_valid stays 1.
- Errors never set data_valid. frame_err and parity_err are never asserted together.

## Timing
- Reset values: data_out = 8'h00; data_valid, frame_err, parity_err, overrun_err = 0; state IDLE; all counters 0.
- Asserting rst_n mid-frame aborts the frame with no outputs. Receive resumes on the first falling edge after release.
- Synchronizer latency: 2 clk from data_in to the synchronized line.
- Sample points, in ticks after the detected edge:
  - start bit: OVERSAMPLE/2
  - data bit k (k = 0..7): OVERSAMPLE/2 + (k+1)·OVERSAMPLE
  - parity bit (macro only): OVERSAMPLE/2 + 9·OVERSAMPLE
  - stop bit: next OVERSAMPLE multiple after the last data or parity sample
- data_valid rises, or the error pulse fires, on the clk after the stop-sample tick.
- Each error pulse lasts exactly 1 clk, independent of rx_en.

## Configuration
- UART_RX_PARITY_EN defined:
  - frame = start, 8 data bits, even parity bit, stop (11 bits);
  - PARITY state is present and parity_err is live.
- UART_RX_PARITY_EN undefined:
  - frame = 8N1 (10 bits);
  - no PARITY state; parity_err is constant 0.

## Test plan
- Reset / idle: hold rst_n = 0, then release with the line high and rx_en every cycle → all outputs at reset values; no activity for 1000 clk.
- Single byte: OVERSAMPLE = 16, send 8'hA5 as 8N1 → data_out = 8'hA5 and data_valid = 1 one clk after the stop sample; data_ack clears data_valid the next clk.
- Glitch: a 4-tick low pulse on an idle line → false start, no outputs, state back to IDLE. Framing error: send 8'h3C with stop = 0 → frame_err pulse, data_valid stays 0, data_out unchanged.
- Overrun: send 8'h11 then 8'h22 back-to-back without data_ack → data_out = 8'h11 and overrun_err pulses at the second stop sample. Repeat with data_ack in the same cycle as the second completion → data_out = 8'h22, no overrun.
- Parity (macro set): 8'h07 with parity 1 → accepted; 8'h07 with parity 0 → parity_err pulse, no data_valid.
- Abort and loopback: pulling rst_n low mid-DATA gives a clean abort, then the next frame 8'hC3 is received correctly. Loopback with the transmitter (tx_en = rx_en/16) over 256 random bytes → all match, in order.
